// File: rtl/cmd_processor.sv
// cmd_processor: dispatches bytes from the I2C slave front end to five graphics engines.
//
// Each byte from the I2C receiver is tagged with its command code (0-4 selects an
// engine; 5 and above are dropped). It is queued and later broadcast on a shared data
// bus, together with a one-cycle one-hot strobe to the selected engine, once that
// engine reports ready-to-receive. Entries leave in arrival order, so a blocked head
// stalls everything behind it.
//
// Build option: define CMD_PROC_FIFO_EN for a DEPTH-entry queue. Without it the queue
// is a single holding register.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_           in   asynchronous active-low reset
//   cmd            in   [7:0] command code for the current byte
//   i2c_in_data    in   [7:0] byte from the I2C receiver
//   i2c_rts        in   byte-available strobe; its rising edge accepts one byte
//   engine_in_rtr  in   [4:0] per-engine ready-to-receive level
//   engine_out_rts out  [4:0] one-hot, one-cycle byte-valid strobe
//   bcast_out_data out  [7:0] broadcast data byte (holds between dispatches)

module cmd_processor #(
    parameter int unsigned DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [7:0] cmd,
    input  logic [7:0] i2c_in_data,
    input  logic       i2c_rts,
    input  logic [4:0] engine_in_rtr,
    output logic [4:0] engine_out_rts,
    output logic [7:0] bcast_out_data
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cmd_processor: DEPTH must be a power of two and at least 2");
    end

    // Entry layout: {engine index[2:0], data[7:0]}
    logic        rts_q;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        head_valid;
    logic [10:0] head;
    logic [10:0] entry_in;
    logic [2:0]  head_cmd;
    logic [4:0]  rts_out_d, rts_out_q;
    logic [7:0]  data_d, data_q;

    // Rising edge of i2c_rts with a valid engine code. Holding i2c_rts high yields one byte.
    assign push_req = i2c_rts & ~rts_q & (cmd < 8'd5);
    assign entry_in = {cmd[2:0], i2c_in_data};
    assign head_cmd = head[10:8];
    // Only codes 0-4 are ever stored, so the index stays in range.
    assign pop      = head_valid & engine_in_rtr[head_cmd];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= i2c_rts;
        end
    end

`ifdef CMD_PROC_FIFO_EN
    localparam int unsigned AW = $clog2(DEPTH);

    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full;

    assign full       = (count_q == (AW + 1)'(DEPTH));
    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    // A full queue still takes a push when the head leaves in the same cycle.
    assign push       = push_req & (~full | pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end
`else
    logic [10:0] hold_q;
    logic        hold_valid_q;

    assign head_valid = hold_valid_q;
    assign head       = hold_q;
    assign push       = push_req & (~hold_valid_q | pop);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push) begin
            hold_q       <= entry_in;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    always_comb begin
        rts_out_d = '0;
        data_d    = data_q;
        if (pop) begin
            rts_out_d = 5'd1 << head_cmd;
            data_d    = head[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rts_out_q <= '0;
            data_q    <= '0;
        end else begin
            rts_out_q <= rts_out_d;
            data_q    <= data_d;
        end
    end

    assign engine_out_rts = rts_out_q;
    assign bcast_out_data = data_q;

endmodule

// File: tb/tb_cmd_processor.sv
// Bench for cmd_processor: a scoreboard queue of expected dispatches is filled as bytes
// are driven and drained by a negedge monitor as strobes appear.
module tb_cmd_processor;
    localparam int unsigned DEPTH = 16;
`ifdef CMD_PROC_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_;
    logic [7:0] cmd;
    logic [7:0] i2c_in_data;
    logic       i2c_rts;
    logic [4:0] engine_in_rtr;
    logic [4:0] engine_out_rts;
    logic [7:0] bcast_out_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int disp_cnt = 0;

    typedef struct {
        logic [4:0] rts;
        logic [7:0] data;
        int         exp_cyc;  // -1 when the dispatch cycle is not checked
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    cmd_processor #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_           (rst_),
        .cmd            (cmd),
        .i2c_in_data    (i2c_in_data),
        .i2c_rts        (i2c_rts),
        .engine_in_rtr  (engine_in_rtr),
        .engine_out_rts (engine_out_rts),
        .bcast_out_data (bcast_out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_ === 1'b1 && engine_out_rts !== 5'b0) begin
            disp_cnt++;
            checks++;
            if (!$onehot(engine_out_rts)) begin
                failures++;
                $display("FAIL onehot: got rts=%b, required exactly one bit hot", engine_out_rts);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_dispatch: got rts=%b data=%h at cycle %0d, required none",
                         engine_out_rts, bcast_out_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if (engine_out_rts !== mon_e.rts) begin
                    failures++;
                    $display("FAIL dispatch_rts: got %b, required %b", engine_out_rts, mon_e.rts);
                end
                checks++;
                if (bcast_out_data !== mon_e.data) begin
                    failures++;
                    $display("FAIL dispatch_data: got %h, required %h", bcast_out_data, mon_e.data);
                end
                if (mon_e.exp_cyc >= 0) begin
                    checks++;
                    if (cyc != mon_e.exp_cyc) begin
                        failures++;
                        $display("FAIL dispatch_cycle: got cycle %0d, required %0d", cyc,
                                 mon_e.exp_cyc);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-cycle i2c_rts pulse; the expected entry is queued if the model has room.
    task automatic pulse(input logic [7:0] c, input logic [7:0] d, input bit timed);
        exp_t e;
        @(posedge clk); #1;
        cmd = c; i2c_in_data = d; i2c_rts = 1'b1;
        @(posedge clk); #1;
        i2c_rts = 1'b0;
        if (c < 8'd5 && exp_q.size() < CAP) begin
            e.rts = 5'd1 << c[2:0];
            e.data = d;
            e.exp_cyc = timed ? cyc + 1 : -1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (4) @(posedge clk);
    endtask

    // Raise ready bits and expect the queued entries on consecutive cycles.
    task automatic raise_rtr(input logic [4:0] r);
        @(posedge clk); #1;
        foreach (exp_q[i]) exp_q[i].exp_cyc = cyc + 1 + i;
        engine_in_rtr = r;
    endtask

    task automatic test_reset();
        int base;
        rst_ = 1'b0; cmd = '0; i2c_in_data = '0; i2c_rts = 1'b0; engine_in_rtr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (engine_out_rts !== 5'b0) begin
            failures++;
            $display("FAIL reset_rts: got %b, required 00000", engine_out_rts);
        end
        checks++;
        if (bcast_out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got %h, required 00", bcast_out_data);
        end
        rst_ = 1'b1;
        base = disp_cnt;
        engine_in_rtr = 5'b11111;
        repeat (5) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL reset_idle: got %0d dispatches, required 0", disp_cnt - base);
        end
    endtask

    task automatic test_fill_rect();
        logic [7:0] pkt [11];
        int base;
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h0F, 8'h00, 8'h00};
        engine_in_rtr = 5'b00010;
        base = disp_cnt;
        foreach (pkt[i]) begin
            pulse(8'd1, pkt[i], 1'b1);
            repeat (18) @(posedge clk);
        end
        drain();
        checks++;
        if (disp_cnt - base != 11 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL fill_rect_count: got %0d dispatches, required 11", disp_cnt - base);
        end
    endtask

    task automatic test_not_ready();
        int base;
        int n_exp;
        n_exp = (CAP < 3) ? CAP : 3;
        engine_in_rtr = 5'b00000;
        base = disp_cnt;
        pulse(8'd2, 8'h11, 1'b0);
        pulse(8'd2, 8'h22, 1'b0);
        pulse(8'd2, 8'h33, 1'b0);
        repeat (10) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL not_ready_stall: got %0d dispatches, required 0", disp_cnt - base);
        end
        raise_rtr(5'b00100);
        drain();
        checks++;
        if (disp_cnt - base != n_exp || exp_q.size() != 0) begin
            failures++;
            $display("FAIL not_ready_count: got %0d dispatches, required %0d", disp_cnt - base,
                     n_exp);
        end
    endtask

    task automatic test_level_invalid();
        int base;
        exp_t e;
        engine_in_rtr = 5'b00001;
        base = disp_cnt;
        @(posedge clk); #1;
        cmd = 8'd0; i2c_in_data = 8'h5A; i2c_rts = 1'b1;
        @(posedge clk); #1;
        e.rts = 5'b00001; e.data = 8'h5A; e.exp_cyc = cyc + 1;
        exp_q.push_back(e);
        repeat (9) @(posedge clk);
        #1;
        i2c_rts = 1'b0;
        drain();
        checks++;
        if (disp_cnt - base != 1) begin
            failures++;
            $display("FAIL level_hold: got %0d dispatches, required 1", disp_cnt - base);
        end
        engine_in_rtr = 5'b11111;
        base = disp_cnt;
        pulse(8'd7, 8'hEE, 1'b0);
        repeat (6) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL invalid_cmd: got %0d dispatches, required 0", disp_cnt - base);
        end
        pulse(8'd4, 8'h44, 1'b1);
        drain();
        checks++;
        if (disp_cnt - base != 1) begin
            failures++;
            $display("FAIL after_invalid: got %0d dispatches, required 1", disp_cnt - base);
        end
    endtask

    task automatic test_overflow();
        int base;
        engine_in_rtr = 5'b00000;
        base = disp_cnt;
        for (int i = 0; i < DEPTH + 2; i++) pulse(8'd0, 8'(i + 8'h80), 1'b0);
        repeat (4) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL overflow_stall: got %0d dispatches, required 0", disp_cnt - base);
        end
        raise_rtr(5'b00001);
        drain();
        checks++;
        if (disp_cnt - base != CAP || exp_q.size() != 0) begin
            failures++;
            $display("FAIL overflow_count: got %0d dispatches, required %0d", disp_cnt - base, CAP);
        end
    endtask

    task automatic test_reset_mid_stream();
        int base;
        engine_in_rtr = 5'b00100;
        pulse(8'd2, 8'hA5, 1'b1);
        drain();
        engine_in_rtr = 5'b00000;
        for (int i = 0; i < 4; i++) pulse(8'd2, 8'(8'hC0 + i), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_ = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (bcast_out_data !== 8'h00) begin
            failures++;
            $display("FAIL midreset_data: got %h, required 00", bcast_out_data);
        end
        checks++;
        if (engine_out_rts !== 5'b0) begin
            failures++;
            $display("FAIL midreset_rts: got %b, required 00000", engine_out_rts);
        end
        @(posedge clk); #1;
        rst_ = 1'b1;
        base = disp_cnt;
        engine_in_rtr = 5'b11111;
        repeat (10) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL midreset_stale: got %0d dispatches, required 0", disp_cnt - base);
        end
    endtask

    task automatic test_head_of_line();
        int base;
        int n_exp;
        n_exp = (CAP >= 2) ? 2 : 1;
        engine_in_rtr = 5'b00010;
        base = disp_cnt;
        pulse(8'd3, 8'h33, 1'b0);
        pulse(8'd1, 8'h01, 1'b0);
        repeat (6) @(posedge clk);
        checks++;
        if (disp_cnt - base != 0) begin
            failures++;
            $display("FAIL hol_stall: got %0d dispatches, required 0", disp_cnt - base);
        end
        raise_rtr(5'b01010);
        drain();
        checks++;
        if (disp_cnt - base != n_exp || exp_q.size() != 0) begin
            failures++;
            $display("FAIL hol_count: got %0d dispatches, required %0d", disp_cnt - base, n_exp);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        engine_in_rtr = 5'b10000;
        base = disp_cnt;
        for (int i = 0; i < 4; i++) pulse(8'd4, 8'(8'h60 + i), 1'b1);
        drain();
        checks++;
        if (disp_cnt - base != 4) begin
            failures++;
            $display("FAIL back_to_back: got %0d dispatches, required 4", disp_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_fill_rect();
        test_not_ready();
        test_level_invalid();
        test_overflow();
        test_reset_mid_stream();
        test_head_of_line();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
